// File: rtl/shift_seq_pkg.sv
// Shared types and default sizing for the serial shift-register loopback sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int SEQ_WIDTH = 8;
  localparam int SR_DELAY  = 33;

endpackage

// File: rtl/shift_seq_ctrl.sv
// Serialises a word MSB-first into an external delay line, recaptures it from the far end
// and reports whether the recovered word matches what was sent.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int DELAY = SR_DELAY
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             stall,
  output logic             sr_enable,
  output logic             sr_shift_in,
  input  logic             sr_out,
  output logic             busy,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             err,
  output seq_state_t       seq_state
);

  // Handshake: a word is taken on a rising edge where tx_valid && tx_ready; tx_ready is high only in IDLE.

  localparam int CW = $clog2(WIDTH + DELAY + 1);
  localparam logic [CW-1:0] LAST_TX  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_ALL = CW'(WIDTH + DELAY - 1);
  localparam logic [CW-1:0] CAP_FROM = CW'(DELAY);

  seq_state_t       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] tx_sh, tx_ref, rx_sh;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tx_valid) state_nxt = SHIFT;
      SHIFT:   if (sr_enable && cnt == LAST_TX) state_nxt = FLUSH;
      FLUSH:   if (sr_enable && cnt == LAST_ALL) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign tx_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign sr_enable   = ((state == SHIFT) || (state == FLUSH)) && !stall;
  assign sr_shift_in = (state == SHIFT) ? tx_sh[WIDTH-1] : 1'b0;
  assign rx_valid    = (state == DONE);
  assign err         = (state == DONE) && (rx_sh != tx_ref);
  assign rx_data     = rx_sh;
  assign seq_state   = state;

  // Capture starts only once the first sent bit has travelled the full delay line,
  // so whatever an earlier word left in the chain is never sampled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      tx_sh  <= '0;
      tx_ref <= '0;
      rx_sh  <= '0;
    end else if (state == IDLE) begin
      if (tx_valid) begin
        tx_sh  <= tx_data;
        tx_ref <= tx_data;
        cnt    <= '0;
      end
    end else if (sr_enable) begin
      cnt <= cnt + 1'b1;
      if (state == SHIFT) tx_sh <= tx_sh << 1;
      if (cnt >= CAP_FROM) rx_sh <= (rx_sh << 1) | WIDTH'(sr_out);
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Loopback bench: sequencer wired to a 33-edge shift register model, scoreboard-checked results.
module tb_shift_seq_ctrl;
  import shift_seq_pkg::*;

  localparam int W = 8;
  localparam int D = 33;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic [W-1:0] tx_data = '0;
  logic         stall = 1'b0;
  logic         sr_enable, sr_shift_in, sr_out;
  logic         busy, rx_valid, err;
  logic [W-1:0] rx_data;
  seq_state_t   seq_state;

  logic [D-1:0] chain;
  logic         sr_force = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_err_q[$];
  int           exp_lat_q[$];
  int           hs_q[$];

  shift_seq_ctrl #(.WIDTH(W), .DELAY(D)) dut (
    .clock(clock), .reset(reset), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .stall(stall), .sr_enable(sr_enable), .sr_shift_in(sr_shift_in),
    .sr_out(sr_out), .busy(busy), .rx_valid(rx_valid), .rx_data(rx_data), .err(err),
    .seq_state(seq_state)
  );

  // clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // shift register: 32 stages plus output register
  always @(posedge clock or negedge reset) begin
    if (!reset) chain <= '0;
    else if (sr_enable) chain <= {chain[D-2:0], sr_shift_in};
  end
  assign sr_out = sr_force ? 1'b1 : chain[D-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (reset && tx_valid && tx_ready) hs_q.push_back(cyc + 1);
      if (reset && rx_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rx_valid", 32'(rx_valid), 32'd0);
        end else begin
          check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
          check("err", 32'(err), 32'(exp_err_q.pop_front()));
          if (hs_q.size() == 0) check("latency_no_handshake", 32'd0, 32'd1);
          else check("latency", 32'(cyc - hs_q.pop_front()), 32'(exp_lat_q.pop_front()));
        end
      end
    end
  end

  // driver tasks
  task automatic expect_word(input logic [W-1:0] d, input logic e, input int lat);
    exp_q.push_back(d);
    exp_err_q.push_back(e);
    exp_lat_q.push_back(lat);
  endtask

  task automatic wait_accept(output int hs);
    int n = 0;
    #1;
    while (!tx_ready && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (!tx_ready) check("accept_timeout", 32'd0, 32'd1);
    hs = cyc + 1;
    @(posedge clock);
  endtask

  task automatic start(input logic [W-1:0] d, output int hs);
    @(negedge clock);
    tx_valid = 1'b1;
    tx_data  = d;
    wait_accept(hs);
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clock);
  endtask

  task automatic stall_for(input int n, input string name);
    @(negedge clock);
    stall = 1'b1;
    repeat (n) begin
      #1;
      check(name, 32'(sr_enable), 32'd0);
      @(negedge clock);
    end
    stall = 1'b0;
  endtask

  initial begin
    int h1, h2;

    // reset state
    #1;
    check("reset_tx_ready", 32'(tx_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_sr_enable", 32'(sr_enable), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // basic word
    expect_word(8'hA5, 1'b0, 41);
    start(8'hA5, h1);
    drain();

    // stall mid-SHIFT and in FLUSH
    expect_word(8'h3C, 1'b0, 49);
    @(negedge clock);
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    wait_accept(h1);
    repeat (3) @(posedge clock);
    tx_valid = 1'b0;
    stall_for(5, "stall_shift_sr_enable");
    repeat (10) @(negedge clock);
    check("flush_state", 32'(seq_state), 32'(FLUSH));
    stall_for(3, "stall_flush_sr_enable");
    drain();

    // back-to-back with tx_valid held high
    expect_word(8'hFF, 1'b0, 41);
    expect_word(8'h00, 1'b0, 41);
    @(negedge clock);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    wait_accept(h1);
    @(negedge clock);
    tx_data = 8'h00;
    wait_accept(h2);
    @(negedge clock);
    tx_valid = 1'b0;
    check("b2b_gap", 32'(h2 - h1), 32'd43);
    drain();

    // forced sr_out during 0x81
    sr_force = 1'b1;
    expect_word(8'hFF, 1'b1, 41);
    start(8'h81, h1);
    drain();
    sr_force = 1'b0;

    // reset mid-transaction
    @(negedge clock);
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    wait_accept(h1);
    repeat (20) @(posedge clock);
    tx_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_mid_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_state", 32'(seq_state), 32'(IDLE));
    hs_q.delete();
    @(negedge clock);
    reset = 1'b1;
    repeat (60) @(negedge clock);
    expect_word(8'h5A, 1'b0, 41);
    start(8'h5A, h1);
    drain();

    // busy refusal
    expect_word(8'h22, 1'b0, 41);
    start(8'h22, h1);
    repeat (5) @(negedge clock);
    tx_valid = 1'b1;
    tx_data  = 8'h11;
    repeat (4) begin
      #1;
      check("busy_tx_ready", 32'(tx_ready), 32'd0);
      @(negedge clock);
    end
    tx_valid = 1'b0;
    drain();
    check("idle_after_refusal", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
